codec_cfg_seq: RTL

CODEC_CFG_SEQ -- requirements
Module: codec_cfg_seq

---
 rtl/codec_cfg_seq_pkg.sv | 39 +++
 rtl/codec_cfg_seq_if.sv | 22 ++
 rtl/codec_cfg_rom.sv | 18 +
 rtl/codec_cfg_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/codec_cfg_seq_pkg.sv
// Shared definitions for the WM8731 configuration sequencer: FSM encoding,
// register map constants and the power-up initialisation table.
package codec_cfg_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    SETTLE    = 3'd4,
    READY     = 3'd5
  } state_t;

  localparam int          INIT_LEN = 12;
  localparam int          IDX_W    = 4;
  localparam int          PKT_W    = 24;
  localparam logic [IDX_W-1:0] LAST_IDX = 4'd11;

  // WM8731 register addresses (7-bit)
  localparam logic [6:0] REG_LLIN_VOL  = 7'h00;
  localparam logic [6:0] REG_RLIN_VOL  = 7'h01;
  localparam logic [6:0] REG_LHP_VOL   = 7'h02;
  localparam logic [6:0] REG_RHP_VOL   = 7'h03;
  localparam logic [6:0] REG_ANA_PATH  = 7'h04;
  localparam logic [6:0] REG_DIG_PATH  = 7'h05;
  localparam logic [6:0] REG_PWR_DOWN  = 7'h06;
  localparam logic [6:0] REG_DAI_FMT   = 7'h07;
  localparam logic [6:0] REG_SMP_CTRL  = 7'h08;
  localparam logic [6:0] REG_ACTIVE    = 7'h09;
  localparam logic [6:0] REG_RESET     = 7'h0F;

  // Entry 0 sits in the most significant slot, so the list reads in write order.
  localparam logic [0:INIT_LEN-1][15:0] INIT_TABLE = {
    16'h1E00, 16'h0C10, 16'h0017, 16'h0217,
    16'h0479, 16'h0679, 16'h0812, 16'h0A00,
    16'h0E02, 16'h1000, 16'h1201, 16'h0C00
  };

endpackage

// File: rtl/codec_cfg_seq_if.sv
// Handshake between the configuration sequencer (master) and the I2C
// byte engine (slave).
interface codec_cfg_seq_if;
  import codec_cfg_seq_pkg::*;

  logic             i2c_idle;
  logic             wr_i2c;
  logic [PKT_W-1:0] i2c_packet;

  modport master (
    input  i2c_idle,
    output wr_i2c,
    output i2c_packet
  );

  modport slave (
    output i2c_idle,
    input  wr_i2c,
    input  i2c_packet
  );

endinterface

// File: rtl/codec_cfg_rom.sv
// Combinational lookup of the 16-bit {addr,data} init word for a table index.
module codec_cfg_rom
  import codec_cfg_seq_pkg::*;
(
  input  logic [IDX_W-1:0] index,
  output logic [15:0]      word
);

  // Out-of-range indices return a harmless all-zero word.
  always_comb begin
    if (index <= LAST_IDX) begin
      word = INIT_TABLE[index];
    end else begin
      word = 16'h0000;
    end
  end

endmodule

// File: rtl/codec_cfg_seq.sv
// WM8731 configuration sequencer: writes the init table over I2C after reset
// or reinit, then serves single runtime register writes.
module codec_cfg_seq
  import codec_cfg_seq_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR      = 8'h34,
  parameter int         SETTLE_CYCLES = 50000,
  parameter int         BUSY_TIMEOUT  = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  codec_cfg_seq_if.master        i2c,
  input  logic                   reinit,
  input  logic                   cfg_req,
  input  logic [6:0]             cfg_addr,
  input  logic [8:0]             cfg_data,
  output logic                   cfg_ack,
  output logic                   init_done,
  output logic                   cfg_busy,
  output logic                   cfg_error
);

  localparam int CNT_MAX = (SETTLE_CYCLES > BUSY_TIMEOUT) ? SETTLE_CYCLES : BUSY_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  state_t             state_r, state_nxt_s;
  logic [IDX_W-1:0]   idx_r, idx_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic               runtime_r, runtime_nxt_s;
  logic [6:0]         addr_r, addr_nxt_s;
  logic [8:0]         data_r, data_nxt_s;
  logic               done_r, done_nxt_s;
  logic               err_r, err_nxt_s;
  logic               ack_r, ack_nxt_s;
  logic               busy_r;
  logic               wr_r;
  logic [PKT_W-1:0]   pkt_r;

  state_t             step_state_s;
  logic [IDX_W-1:0]   step_idx_s;
  logic               step_done_s;
  logic               step_ack_s;
  logic [15:0]        rom_word_s;
  logic [15:0]        word_s;

  codec_cfg_rom u_rom (
    .index (idx_r),
    .word  (rom_word_s)
  );

  // Payload for the next ISSUE: latched runtime request or the current table entry.
  always_comb begin
    if (runtime_r) begin
      word_s = {addr_r, data_r};
    end else begin
      word_s = rom_word_s;
    end
  end

  // Where to go once the current write has finished (normally or by timeout).
  always_comb begin
    step_state_s = WAIT_IDLE;
    step_idx_s   = idx_r;
    step_done_s  = done_r;
    step_ack_s   = 1'b0;
    if (runtime_r) begin
      step_state_s = READY;
      step_ack_s   = 1'b1;
    end else if (idx_r == 4'd0) begin
      step_state_s = SETTLE;
    end else if (idx_r == LAST_IDX) begin
      step_state_s = READY;
      step_done_s  = 1'b1;
    end else begin
      step_idx_s   = idx_r + 4'd1;
    end
  end

  // Next-state logic; reinit overrides everything, including a runtime write.
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    cnt_nxt_s     = cnt_r;
    runtime_nxt_s = runtime_r;
    addr_nxt_s    = addr_r;
    data_nxt_s    = data_r;
    done_nxt_s    = done_r;
    err_nxt_s     = err_r;
    ack_nxt_s     = 1'b0;
    if (reinit) begin
      state_nxt_s   = WAIT_IDLE;
      idx_nxt_s     = 4'd0;
      cnt_nxt_s     = '0;
      runtime_nxt_s = 1'b0;
      done_nxt_s    = 1'b0;
      err_nxt_s     = 1'b0;
    end else begin
      case (state_r)
        WAIT_IDLE: begin
          if (i2c.i2c_idle) begin
            state_nxt_s = ISSUE;
          end else begin
            state_nxt_s = WAIT_IDLE;
          end
        end
        ISSUE: begin
          state_nxt_s = WAIT_BUSY;
          cnt_nxt_s   = '0;
        end
        WAIT_BUSY: begin
          if (!i2c.i2c_idle) begin
            state_nxt_s = WAIT_DONE;
            cnt_nxt_s   = '0;
          end else if (cnt_r == TIMEOUT_LAST) begin
            err_nxt_s     = 1'b1;
            state_nxt_s   = step_state_s;
            idx_nxt_s     = step_idx_s;
            done_nxt_s    = step_done_s;
            ack_nxt_s     = step_ack_s;
            runtime_nxt_s = 1'b0;
            cnt_nxt_s     = '0;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (i2c.i2c_idle) begin
            state_nxt_s   = step_state_s;
            idx_nxt_s     = step_idx_s;
            done_nxt_s    = step_done_s;
            ack_nxt_s     = step_ack_s;
            runtime_nxt_s = 1'b0;
            cnt_nxt_s     = '0;
          end else begin
            state_nxt_s = WAIT_DONE;
          end
        end
        SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            state_nxt_s = WAIT_IDLE;
            idx_nxt_s   = 4'd1;
            cnt_nxt_s   = '0;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        READY: begin
          // The ack cycle is skipped so a requester still holding cfg_req is not re-served.
          if (cfg_req && done_r && !ack_r) begin
            state_nxt_s   = WAIT_IDLE;
            runtime_nxt_s = 1'b1;
            addr_nxt_s    = cfg_addr;
            data_nxt_s    = cfg_data;
          end else begin
            state_nxt_s = READY;
          end
        end
        default: begin
          state_nxt_s   = WAIT_IDLE;
          idx_nxt_s     = 4'd0;
          cnt_nxt_s     = '0;
          runtime_nxt_s = 1'b0;
          done_nxt_s    = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs; wr_i2c/packet follow the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= WAIT_IDLE;
      idx_r     <= 4'd0;
      cnt_r     <= '0;
      runtime_r <= 1'b0;
      addr_r    <= 7'd0;
      data_r    <= 9'd0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      ack_r     <= 1'b0;
      busy_r    <= 1'b1;
      wr_r      <= 1'b0;
      pkt_r     <= 24'd0;
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      cnt_r     <= cnt_nxt_s;
      runtime_r <= runtime_nxt_s;
      addr_r    <= addr_nxt_s;
      data_r    <= data_nxt_s;
      done_r    <= done_nxt_s;
      err_r     <= err_nxt_s;
      ack_r     <= ack_nxt_s;
      busy_r    <= (state_nxt_s != READY);
      wr_r      <= (state_nxt_s == ISSUE);
      if (state_nxt_s == ISSUE) begin
        pkt_r <= {DEV_ADDR, word_s};
      end else begin
        pkt_r <= pkt_r;
      end
    end
  end

  assign i2c.wr_i2c     = wr_r;
  assign i2c.i2c_packet = pkt_r;
  assign cfg_ack        = ack_r;
  assign init_done      = done_r;
  assign cfg_busy       = busy_r;
  assign cfg_error      = err_r;

endmodule
